dct_ser8xn_unload: RTL and testbench

- Parallel-to-serial unloader, the read-side counterpart of the 8-word serial-capture register bank.
- Accepts a full row of 8 WIDTH-bit DCT partial products in one cycle.
- Streams the row out one word per transfer, with word address and row/block position, to the transpose memory / quantiser path.
- Double-buffered (active + pending row) so back-to-back rows stream with no bubbles.

---
 rtl/dct_ser8xn_unload.sv | 128 ++++++++++++
 tb/tb_dct_ser8xn_unload.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dct_ser8xn_unload.sv
// ============================================================================
// Module   : dct_ser8xn_unload
// Function : Double-buffered 8-word row unloader for the DCT transpose path.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dct_ser8xn_unload #(
   parameter int WIDTH = 11
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ld,
   input  logic [WIDTH-1:0] d0,
   input  logic [WIDTH-1:0] d1,
   input  logic [WIDTH-1:0] d2,
   input  logic [WIDTH-1:0] d3,
   input  logic [WIDTH-1:0] d4,
   input  logic [WIDTH-1:0] d5,
   input  logic [WIDTH-1:0] d6,
   input  logic [WIDTH-1:0] d7,
   output logic             ld_ready,
   output logic [WIDTH-1:0] dout,
   output logic [2:0]       ra,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic [2:0]       row,
   output logic             last,
   output logic             blk_last
);

   localparam logic [2:0] C_LAST_IDX = 3'd7;

   logic [WIDTH-1:0] a_q [8];
   logic [WIDTH-1:0] a_d [8];
   logic [WIDTH-1:0] p_q [8];
   logic [WIDTH-1:0] p_d [8];
   logic             busy_q, busy_d;
   logic             pend_q, pend_d;
   logic [2:0]       cnt_q, cnt_d;
   logic [2:0]       rowcnt_q, rowcnt_d;

   logic [WIDTH-1:0] w_din [8];
   logic             w_xfer;
   logic             w_done;
   logic             w_acc;

   always_comb begin
      w_din[0] = d0;
      w_din[1] = d1;
      w_din[2] = d2;
      w_din[3] = d3;
      w_din[4] = d4;
      w_din[5] = d5;
      w_din[6] = d6;
      w_din[7] = d7;
   end

   assign w_xfer = busy_q & dout_ready;
   assign w_done = w_xfer & (cnt_q == C_LAST_IDX);
   assign w_acc  = ld & ~pend_q;

   always_comb begin
      a_d      = a_q;
      p_d      = p_q;
      busy_d   = busy_q;
      pend_d   = pend_q;
      cnt_d    = cnt_q;
      rowcnt_d = rowcnt_q;

      if (w_xfer && !w_done) begin
         cnt_d = cnt_q + 3'd1;
      end
      if (w_done) begin
         rowcnt_d = rowcnt_q + 3'd1;
      end

      // A load landing on an idle unit or on the final transfer bypasses P,
      // which is what keeps back-to-back rows free of bubbles.
      if (w_acc && (!busy_q || w_done)) begin
         a_d    = w_din;
         cnt_d  = 3'd0;
         busy_d = 1'b1;
      end else if (w_acc) begin
         p_d    = w_din;
         pend_d = 1'b1;
      end else if (w_done) begin
         cnt_d = 3'd0;
         if (pend_q) begin
            a_d    = p_q;
            pend_d = 1'b0;
         end else begin
            busy_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) begin
            a_q[i] <= '0;
            p_q[i] <= '0;
         end
         busy_q   <= 1'b0;
         pend_q   <= 1'b0;
         cnt_q    <= 3'd0;
         rowcnt_q <= 3'd0;
      end else begin
         a_q      <= a_d;
         p_q      <= p_d;
         busy_q   <= busy_d;
         pend_q   <= pend_d;
         cnt_q    <= cnt_d;
         rowcnt_q <= rowcnt_d;
      end
   end

   assign dout       = a_q[cnt_q];
   assign ra         = cnt_q;
   assign dout_valid = busy_q;
   assign row        = rowcnt_q;
   assign ld_ready   = ~pend_q;
   assign last       = busy_q & (cnt_q == C_LAST_IDX);
   assign blk_last   = last & (rowcnt_q == C_LAST_IDX);

endmodule

`default_nettype wire

// File: tb/tb_dct_ser8xn_unload.sv
// ============================================================================
// Module   : tb_dct_ser8xn_unload
// Function : Self-checking bench for dct_ser8xn_unload (vector table + scoreboard).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dct_ser8xn_unload;

   localparam int W = 11;

   logic         clk;
   logic         rst_n;
   logic         ld;
   logic [W-1:0] din [8];
   logic         ld_ready;
   logic [W-1:0] dout;
   logic [2:0]   ra;
   logic         dout_valid;
   logic         dout_ready;
   logic [2:0]   row;
   logic         last;
   logic         blk_last;

   int total = 0;
   int bad   = 0;
   int blk_seen = 0;
   int row_model = 0;

   typedef struct {
      logic [W-1:0] d;
      logic [2:0]   ra;
      logic [2:0]   row;
      logic         last;
      logic         blk;
   } exp_t;
   exp_t sbq[$];

   typedef struct {
      logic         ld;
      logic [W-1:0] base;
      logic         e_ldr;
      logic         e_v;
      logic [2:0]   e_ra;
      logic [2:0]   e_row;
      logic         e_last;
   } vec_t;
   vec_t tbl[18];

   dct_ser8xn_unload #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ld         (ld),
      .d0         (din[0]),
      .d1         (din[1]),
      .d2         (din[2]),
      .d3         (din[3]),
      .d4         (din[4]),
      .d5         (din[5]),
      .d6         (din[6]),
      .d7         (din[7]),
      .ld_ready   (ld_ready),
      .dout       (dout),
      .ra         (ra),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .row        (row),
      .last       (last),
      .blk_last   (blk_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_row(input int base);
      for (int i = 0; i < 8; i++) din[i] = W'(base + i);
   endtask

   function automatic vec_t mk(input logic l, input int b, input logic r, input logic v,
                               input int a, input int rw, input logic lst);
      vec_t t;
      t.ld = l; t.base = W'(b); t.e_ldr = r; t.e_v = v;
      t.e_ra = 3'(a); t.e_row = 3'(rw); t.e_last = lst;
      return t;
   endfunction

   task automatic wait_drain(input string name, input int budget);
      int n = 0;
      while (!(sbq.size() == 0 && !dout_valid) && n < budget) begin
         step();
         n++;
      end
      chk({name, "_drain_timeout"}, (n < budget) ? 1 : 0, 1);
   endtask

   task automatic wait_ra(input string name, input int target, input int budget);
      int n = 0;
      while (!(dout_valid && ra == 3'(target)) && n < budget) begin
         step();
         n++;
      end
      chk({name, "_wait_timeout"}, (n < budget) ? 1 : 0, 1);
   endtask

   // Scoreboard: accepted rows are queued, every transfer pops one word.
   always @(negedge clk) begin
      if (rst_n) begin
         if (dout_valid && dout_ready) begin
            if (sbq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_word: got dout=%0d ra=%0d expected no word", dout, ra);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               chk("sb_dout", int'(dout), int'(e.d));
               chk("sb_ra", int'(ra), int'(e.ra));
               chk("sb_row", int'(row), int'(e.row));
               chk("sb_last", int'(last), int'(e.last));
               chk("sb_blk_last", int'(blk_last), int'(e.blk));
               if (blk_last) blk_seen++;
            end
         end else if (!dout_valid) begin
            chk("idle_last", int'(last), 0);
         end
         if (ld && ld_ready) begin
            for (int i = 0; i < 8; i++) begin
               exp_t e;
               e.d = din[i];
               e.ra = 3'(i);
               e.row = 3'(row_model);
               e.last = (i == 7);
               e.blk = (i == 7) && (row_model == 7);
               sbq.push_back(e);
            end
            row_model = (row_model + 1) % 8;
         end
      end
   end

   initial begin
      tbl[0]  = mk(1, 100, 1, 0, 0, 0, 0);
      tbl[1]  = mk(1, 200, 1, 1, 0, 0, 0);
      tbl[2]  = mk(0, 0,   0, 1, 1, 0, 0);
      tbl[3]  = mk(0, 0,   0, 1, 2, 0, 0);
      tbl[4]  = mk(0, 0,   0, 1, 3, 0, 0);
      tbl[5]  = mk(0, 0,   0, 1, 4, 0, 0);
      tbl[6]  = mk(0, 0,   0, 1, 5, 0, 0);
      tbl[7]  = mk(0, 0,   0, 1, 6, 0, 0);
      tbl[8]  = mk(0, 0,   0, 1, 7, 0, 1);
      tbl[9]  = mk(0, 0,   1, 1, 0, 1, 0);
      tbl[10] = mk(0, 0,   1, 1, 1, 1, 0);
      tbl[11] = mk(0, 0,   1, 1, 2, 1, 0);
      tbl[12] = mk(0, 0,   1, 1, 3, 1, 0);
      tbl[13] = mk(0, 0,   1, 1, 4, 1, 0);
      tbl[14] = mk(0, 0,   1, 1, 5, 1, 0);
      tbl[15] = mk(0, 0,   1, 1, 6, 1, 0);
      tbl[16] = mk(0, 0,   1, 1, 7, 1, 1);
      tbl[17] = mk(0, 0,   1, 0, 0, 2, 0);

      rst_n = 1'b0;
      ld = 1'b0;
      dout_ready = 1'b1;
      set_row(0);
      step();
      step();
      chk("rst_dout", int'(dout), 0);
      chk("rst_ra", int'(ra), 0);
      chk("rst_valid", int'(dout_valid), 0);
      chk("rst_row", int'(row), 0);
      chk("rst_last", int'(last), 0);
      chk("rst_blk_last", int'(blk_last), 0);
      chk("rst_ld_ready", int'(ld_ready), 1);
      rst_n = 1'b1;
      step();

      // back-to-back rows, cycle-accurate vector table
      for (int k = 0; k < 18; k++) begin
         ld = tbl[k].ld;
         set_row(int'(tbl[k].base));
         @(negedge clk);
         chk("tbl_ld_ready", int'(ld_ready), int'(tbl[k].e_ldr));
         chk("tbl_valid", int'(dout_valid), int'(tbl[k].e_v));
         chk("tbl_ra", int'(ra), int'(tbl[k].e_ra));
         chk("tbl_row", int'(row), int'(tbl[k].e_row));
         chk("tbl_last", int'(last), int'(tbl[k].e_last));
         step();
      end
      ld = 1'b0;
      wait_drain("tbl", 20);

      // single row 10..17, first word one cycle after load
      ld = 1'b1;
      set_row(10);
      step();
      ld = 1'b0;
      @(negedge clk);
      chk("single_first_dout", int'(dout), 10);
      chk("single_first_valid", int'(dout_valid), 1);
      chk("single_ld_ready", int'(ld_ready), 1);
      wait_drain("single", 20);

      // stall of 5 cycles while word 3 (0x2A3) is presented
      ld = 1'b1;
      set_row(12'h2A0);
      step();
      ld = 1'b0;
      wait_ra("stall", 3, 20);
      dout_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_dout", int'(dout), 'h2A3);
         chk("stall_ra", int'(ra), 3);
         step();
      end
      dout_ready = 1'b1;
      @(negedge clk);
      chk("stall_resume_ra3", int'(ra), 3);
      step();
      chk("stall_resume_ra4", int'(ra), 4);
      wait_drain("stall", 20);

      // third load while a row is pending must be ignored
      ld = 1'b1;
      set_row(300);
      step();
      set_row(400);
      step();
      set_row(500);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("ignored_ld_ready", int'(ld_ready), 0);
         step();
      end
      ld = 1'b0;
      wait_drain("ignored", 30);

      // load coinciding with the final transfer goes straight to the active row
      ld = 1'b1;
      set_row(600);
      step();
      ld = 1'b0;
      wait_ra("done_ld", 7, 20);
      ld = 1'b1;
      set_row(700);
      @(negedge clk);
      chk("done_ld_ready", int'(ld_ready), 1);
      step();
      ld = 1'b0;
      @(negedge clk);
      chk("done_ld_valid", int'(dout_valid), 1);
      chk("done_ld_ra", int'(ra), 0);
      chk("done_ld_dout", int'(dout), 700);
      chk("done_ld_nopend", int'(ld_ready), 1);
      wait_drain("done_ld", 20);

      // nine rows at one load per 8 cycles: continuous stream, one blk_last
      blk_seen = 0;
      for (int r = 0; r < 9; r++) begin
         for (int c = 0; c < 8; c++) begin
            ld = (c == 0);
            set_row(1000 + r * 16);
            if (!(r == 0 && c == 0)) begin
               @(negedge clk);
               chk("thru_valid", int'(dout_valid), 1);
            end
            step();
         end
      end
      ld = 1'b0;
      @(negedge clk);
      chk("thru_valid_tail", int'(dout_valid), 1);
      chk("thru_row_wrapped", int'(row), 0);
      wait_drain("thru", 20);
      chk("thru_blk_count", blk_seen, 1);

      // asynchronous reset in mid-row
      ld = 1'b1;
      set_row(1500);
      step();
      ld = 1'b0;
      wait_ra("arst", 4, 20);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", int'(dout_valid), 0);
      chk("arst_ra", int'(ra), 0);
      chk("arst_row", int'(row), 0);
      chk("arst_ld_ready", int'(ld_ready), 1);
      chk("arst_dout", int'(dout), 0);
      sbq.delete();
      row_model = 0;
      step();
      rst_n = 1'b1;
      step();
      ld = 1'b1;
      set_row(1600);
      step();
      ld = 1'b0;
      @(negedge clk);
      chk("post_rst_ra", int'(ra), 0);
      chk("post_rst_dout", int'(dout), 1600);
      chk("post_rst_row", int'(row), 0);
      wait_drain("post_rst", 20);

      chk("sb_empty", sbq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule

`default_nettype wire
